// File: rtl/apb_reg_slave.sv
// APB-style register-bank slave: read-only ID at index 0, read/write registers above it,
// programmable wait states and a sticky protocol-violation flag.
module apb_reg_slave #(
   parameter int unsigned        ADDR_W      = 8,
   parameter int unsigned        DATA_W      = 32,
   parameter int unsigned        NUM_REGS    = 16,
   parameter int unsigned        WAIT_CYCLES = 1,
   parameter logic [DATA_W-1:0]  ID_VALUE    = 'hA5A5_0001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              ready,
   output logic              slverr,
   output logic              proto_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q, state_d;
   state_t              phase;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                ready_q, ready_d;
   logic                slverr_q, slverr_d;
   logic                proto_err_q, proto_err_d;
   logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
   logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];

   logic [ADDR_W-1:0]   acc_addr;
   logic                acc_wr;
   logic                in_range;
   logic                resp_err;
   logic [DATA_W-1:0]   resp_rd;
   logic [DATA_W-1:0]   reg_val;
   logic                mismatch;

   // Response for the access being served: straight from the bus while the
   // setup phase is being accepted, from the captured copy afterwards.
   always_comb begin
      acc_addr = (state_q == IDLE) ? addr  : addr_q;
      acc_wr   = (state_q == IDLE) ? wr_en : wr_en_q;
      in_range = 32'(acc_addr) < NUM_REGS;
      reg_val  = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (acc_addr == ADDR_W'(i)) reg_val = regs_q[i];
      end
      if (acc_wr) begin
         resp_err = (acc_addr == '0) || !in_range;
         resp_rd  = '0;
      end else begin
         resp_err = !in_range;
         if (acc_addr == '0)  resp_rd = ID_VALUE;
         else if (in_range)   resp_rd = reg_val;
         else                 resp_rd = '0;
      end
   end

   // The setup phase is recognised from the bus while the register still
   // holds IDLE, so a zero-wait access can raise ready in its first cycle.
   always_comb begin
      phase = state_q;
      if (state_q == IDLE && sel && !en) phase = SETUP;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wr_en_d     = wr_en_q;
      wr_data_d   = wr_data_q;
      rd_data_d   = '0;
      ready_d     = 1'b0;
      slverr_d    = 1'b0;
      proto_err_d = proto_err_q;
      regs_d      = regs_q;
      mismatch    = (addr != addr_q) || (wr_en != wr_en_q) || (wr_data != wr_data_q);

      case (phase)
         IDLE: begin
            if (sel && en) proto_err_d = 1'b1;
         end
         SETUP: begin
            addr_d    = addr;
            wr_en_d   = wr_en;
            wr_data_d = wr_data;
            cnt_d     = 4'(WAIT_CYCLES);
            state_d   = ACCESS;
            if (WAIT_CYCLES == 0) begin
               ready_d   = 1'b1;
               rd_data_d = resp_rd;
               slverr_d  = resp_err;
            end
         end
         ACCESS: begin
            if (!sel) begin
               state_d = IDLE;
            end else begin
               if (!en || mismatch) proto_err_d = 1'b1;
               if (ready_q) begin
                  if (en) begin
                     state_d = IDLE;
                     if (wr_en_q && !slverr_q) begin
                        for (int unsigned i = 1; i < NUM_REGS; i++) begin
                           if (addr_q == ADDR_W'(i)) regs_d[i] = wr_data_q;
                        end
                     end
                  end else begin
                     ready_d   = ready_q;
                     rd_data_d = rd_data_q;
                     slverr_d  = slverr_q;
                  end
               end else if (en) begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     ready_d   = 1'b1;
                     rd_data_d = resp_rd;
                     slverr_d  = resp_err;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         rd_data_q   <= '0;
         ready_q     <= 1'b0;
         slverr_q    <= 1'b0;
         proto_err_q <= 1'b0;
         regs_q      <= '{default: '0};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         rd_data_q   <= rd_data_d;
         ready_q     <= ready_d;
         slverr_q    <= slverr_d;
         proto_err_q <= proto_err_d;
         regs_q      <= regs_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign ready     = ready_q;
   assign slverr    = slverr_q;
   assign proto_err = proto_err_q;

endmodule
